// File: rtl/pkt_defs.sv
// Shared packet-header definitions: type codes, header byte layout, parser FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_defs;

   // Packet type codes carried in bits [2:0] of header byte 0
   localparam logic [2:0] PKT_HB   = 3'b000;  // heartbeat
   localparam logic [2:0] PKT_CHE  = 3'b001;  // CH-election
   localparam logic [2:0] PKT_DATA = 3'b010;  // data
   localparam logic [2:0] PKT_INV  = 3'b011;  // CH-invite
   localparam logic [2:0] PKT_JOIN = 3'b100;  // join
   localparam logic [2:0] PKT_RECL = 3'b101;  // recluster
   localparam logic [2:0] PKT_IDLE = 3'b111;  // idle / no packet

   // Header layout, byte offsets from header start; multi-byte fields are MSB first
   localparam int HDR_LEN    = 10;
   localparam int OFS_TYPE   = 0;
   localparam int OFS_SRC    = 1;
   localparam int OFS_DST    = 3;
   localparam int OFS_HOPS   = 5;
   localparam int OFS_ENERGY = 6;
   localparam int OFS_QVAL   = 8;

   // Byte index counter width; must hold HDR_LEN
   localparam int IDX_WIDTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Codes 110 and 111 do not name a packet type
   function automatic logic type_valid(input logic [2:0] t);
      return (t <= PKT_RECL);
   endfunction

endpackage

// File: rtl/pkt_hdr_shadow.sv
// Shadow registers for header bytes, written by byte index, assembled into header fields.
// Latency: field outputs include a byte written this cycle (write-through view).
// Backpressure: none; accepts one byte per cycle whenever wr_en is high.
module pkt_hdr_shadow
   import pkt_defs::*;
#(
   parameter int MEM_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [IDX_WIDTH-1:0]   wr_idx,
   input  logic [MEM_WIDTH-1:0]   wr_dat,
   output logic [2:0]             typ,
   output logic [2*MEM_WIDTH-1:0] src,
   output logic [2*MEM_WIDTH-1:0] dst,
   output logic [MEM_WIDTH-1:0]   hops,
   output logic [2*MEM_WIDTH-1:0] energy,
   output logic [2*MEM_WIDTH-1:0] qval
);

   // Only the type bits of byte 0 carry meaning, so only those are stored
   logic [2:0]           typ_q;
   logic [MEM_WIDTH-1:0] byte_q [1:HDR_LEN-1];
   logic [MEM_WIDTH-1:0] byte_v [1:HDR_LEN-1];

   // Write-through view: stored bytes with this cycle's incoming byte merged in
   always_comb begin
      typ = (wr_en && (wr_idx == IDX_WIDTH'(OFS_TYPE))) ? wr_dat[2:0] : typ_q;
      for (int i = 1; i < HDR_LEN; i++) begin
         byte_v[i] = (wr_en && (wr_idx == IDX_WIDTH'(i))) ? wr_dat : byte_q[i];
      end
   end

   // Commit the merged view; reset discards any partially captured header
   always_ff @(posedge clk) begin
      if (rst) begin
         typ_q <= '0;
         for (int i = 1; i < HDR_LEN; i++) begin
            byte_q[i] <= '0;
         end
      end else begin
         typ_q <= typ;
         for (int i = 1; i < HDR_LEN; i++) begin
            byte_q[i] <= byte_v[i];
         end
      end
   end

   assign src    = {byte_v[OFS_SRC],    byte_v[OFS_SRC+1]};
   assign dst    = {byte_v[OFS_DST],    byte_v[OFS_DST+1]};
   assign hops   =  byte_v[OFS_HOPS];
   assign energy = {byte_v[OFS_ENERGY], byte_v[OFS_ENERGY+1]};
   assign qval   = {byte_v[OFS_QVAL],   byte_v[OFS_QVAL+1]};

endmodule

// File: rtl/pkt_header_parser.sv
// Reads a 10-byte packet header from receive memory and presents registered header fields.
// Latency: start -> newpkt/pkt_err 12 cycles; next start accepted 13 cycles after the first.
// Backpressure: none; start while busy is ignored, memory must return data one cycle after a read.
module pkt_header_parser
   import pkt_defs::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int MEM_WIDTH  = 8,
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [MEM_WIDTH-1:0]  mem_rdata,
   output logic [2:0]            fPktType,
   output logic [WORD_WIDTH-1:0] fSourceID,
   output logic [WORD_WIDTH-1:0] destinationID,
   output logic [7:0]            fHops,
   output logic [WORD_WIDTH-1:0] fEnergy,
   output logic [WORD_WIDTH-1:0] fQValue,
   output logic                  newpkt,
   output logic                  pkt_err,
   output logic                  busy
);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [IDX_WIDTH-1:0]    idx_q;
   logic                    cap_vld_q;
   logic [IDX_WIDTH-1:0]    cap_idx_q;

   logic [2:0]              sh_typ;
   logic [2*MEM_WIDTH-1:0]  sh_src, sh_dst, sh_energy, sh_qval;
   logic [MEM_WIDTH-1:0]    sh_hops;

   logic                    last_issue;
   logic                    hdr_done;
   logic                    hdr_ok;

   assign last_issue = (idx_q == IDX_WIDTH'(HDR_LEN - 1));

   // The final byte is on mem_rdata during DRAIN; the shadow's write-through view
   // already contains it, so the output registers load on the DRAIN->DONE edge and
   // the strobe and fields appear together in the DONE cycle.
   assign hdr_done = (state_q == ST_DRAIN);
   assign hdr_ok   = type_valid(sh_typ);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and memory-side outputs
   always_comb begin
      state_d   = state_q;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      busy      = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            mem_rd_en = 1'b1;
            mem_addr  = base_q + ADDR_WIDTH'(idx_q);  // wraps modulo memory size
            if (last_issue) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Base/index sequencing and the one-cycle-delayed capture slot for returning bytes
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q    <= '0;
         idx_q     <= '0;
         cap_vld_q <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         cap_vld_q <= mem_rd_en;
         cap_idx_q <= idx_q;
         if ((state_q == ST_IDLE) && start) begin
            base_q <= base_addr;
            idx_q  <= '0;
         end else if (state_q == ST_READ) begin
            idx_q  <= idx_q + IDX_WIDTH'(1);
         end
      end
   end

   pkt_hdr_shadow #(
      .MEM_WIDTH (MEM_WIDTH)
   ) u_shadow (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (cap_vld_q),
      .wr_idx (cap_idx_q),
      .wr_dat (mem_rdata),
      .typ    (sh_typ),
      .src    (sh_src),
      .dst    (sh_dst),
      .hops   (sh_hops),
      .energy (sh_energy),
      .qval   (sh_qval)
   );

   // Result strobes, and field registers that change only when a valid header completes
   always_ff @(posedge clk) begin
      if (rst) begin
         newpkt        <= 1'b0;
         pkt_err       <= 1'b0;
         fPktType      <= '0;
         fSourceID     <= '0;
         destinationID <= '0;
         fHops         <= '0;
         fEnergy       <= '0;
         fQValue       <= '0;
      end else begin
         newpkt  <= hdr_done && hdr_ok;
         pkt_err <= hdr_done && !hdr_ok;
         if (hdr_done && hdr_ok) begin
            fPktType      <= sh_typ;
            fSourceID     <= sh_src;
            destinationID <= sh_dst;
            fHops         <= sh_hops;
            fEnergy       <= sh_energy;
            fQValue       <= sh_qval;
         end
      end
   end

endmodule

// File: tb/tb_pkt_header_parser.sv
// Randomized scoreboard bench for pkt_header_parser with a behavioural memory and header model.
// Latency: expects strobes 12 cycles after the start cycle.
// Backpressure: none modelled; next start issued 13 cycles after the previous one.
module tb_pkt_header_parser;
   import pkt_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] base_addr = '0;
   logic        mem_rd_en;
   logic [10:0] mem_addr;
   logic [7:0]  mem_rdata = '0;
   logic [2:0]  fPktType;
   logic [15:0] fSourceID, destinationID, fEnergy, fQValue;
   logic [7:0]  fHops;
   logic        newpkt, pkt_err, busy;

   pkt_header_parser dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .mem_rd_en     (mem_rd_en),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .fPktType      (fPktType),
      .fSourceID     (fSourceID),
      .destinationID (destinationID),
      .fHops         (fHops),
      .fEnergy       (fEnergy),
      .fQValue       (fQValue),
      .newpkt        (newpkt),
      .pkt_err       (pkt_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Cycle k is the period following the k-th rising edge
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic rst_seen = 1'b1;
   always @(posedge clk) rst_seen <= rst;

   // Receive memory: data returned one cycle after the read strobe
   logic [7:0] mem [2048];
   always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'h5A;

   typedef struct {
      bit          err;
      logic [2:0]  typ;
      logic [15:0] src, dst, energy, qval;
      logic [7:0]  hops;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] addr_q[$];
   exp_t        model = '{err: 0, typ: 0, src: 0, dst: 0, energy: 0, qval: 0, hops: 0, cyc: 0};
   logic [7:0]  pb [10];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Monitor: address stream, strobes against the scoreboard, and held output fields
   always @(negedge clk) begin
      if (rst_seen) begin
         exp_q.delete();
         addr_q.delete();
         model = '{err: 0, typ: 0, src: 0, dst: 0, energy: 0, qval: 0, hops: 0, cyc: 0};
      end else if (!rst) begin
         if (mem_rd_en) begin
            if (addr_q.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF);
            else chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
         end else begin
            chk("mem_addr_idle", 32'(mem_addr), 32'h0);
         end
         chk("strobe_exclusive", 32'(newpkt && pkt_err), 32'h0);
         if (newpkt || pkt_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("strobe_kind_err", 32'(pkt_err), 32'(e.err));
               chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
               if (!e.err) model = e;
            end
         end
         chk("fPktType", 32'(fPktType), 32'(model.typ));
         chk("fSourceID", 32'(fSourceID), 32'(model.src));
         chk("destinationID", 32'(destinationID), 32'(model.dst));
         chk("fHops", 32'(fHops), 32'(model.hops));
         chk("fEnergy", 32'(fEnergy), 32'(model.energy));
         chk("fQValue", 32'(fQValue), 32'(model.qval));
      end
   end

   // mode 0: plain parse; 1: extra start while busy; 2: reset in the middle
   task automatic run_pkt(input logic [10:0] base, input int mode);
      exp_t e;
      int   t;
      for (int i = 0; i < HDR_LEN; i++) begin
         logic [10:0] a;
         a = 11'((int'(base) + i) % 2048);
         mem[a] = pb[i];
         addr_q.push_back(a);
      end
      e.typ    = pb[0][2:0];
      e.err    = (pb[0][2:0] == 3'b110) || (pb[0][2:0] == 3'b111);
      e.src    = {pb[1], pb[2]};
      e.dst    = {pb[3], pb[4]};
      e.hops   = pb[5];
      e.energy = {pb[6], pb[7]};
      e.qval   = {pb[8], pb[9]};
      e.cyc    = cyc + 12;
      exp_q.push_back(e);

      t         = cyc;
      start     = 1'b1;
      base_addr = base;
      @(negedge clk);
      start     = 1'b0;
      base_addr = 11'($urandom);

      if (mode == 2) begin
         while (cyc < t + 6) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
         chk("rst_newpkt", 32'(newpkt), 32'h0);
         chk("rst_pkt_err", 32'(pkt_err), 32'h0);
         chk("rst_fields", {fSourceID, destinationID}, 32'h0);
         chk("rst_fields2", {fEnergy, fQValue}, 32'h0);
         chk("rst_type_hops", {21'h0, fPktType, fHops}, 32'h0);
         @(negedge clk);
      end else begin
         if (mode == 1) begin
            while (cyc < t + 5) @(negedge clk);
            start     = 1'b1;
            base_addr = base + 11'd100;
            @(negedge clk);
            start     = 1'b0;
         end
         while (cyc < t + 12) @(negedge clk);
         chk("busy_done_cycle", 32'(busy), 32'h1);
         @(negedge clk);
         chk("busy_after", 32'(busy), 32'h0);
      end
   endtask

   task automatic rand_bytes();
      for (int i = 0; i < HDR_LEN; i++) pb[i] = 8'($urandom);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_strobes", {30'h0, newpkt, pkt_err}, 32'h0);
      chk("reset_rd", {20'h0, mem_rd_en, mem_addr}, 32'h0);
      chk("reset_fields", {fSourceID, destinationID}, 32'h0);
      chk("reset_fields2", {fEnergy, fQValue}, 32'h0);
      chk("reset_type_hops", {21'h0, fPktType, fHops}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Heartbeat
      pb = '{8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h05, 8'h03, 8'hE8, 8'h00, 8'h7F};
      run_pkt(11'h010, 0);
      // Invalid type: fields must keep the heartbeat values
      rand_bytes();
      pb[0] = 8'h07;
      run_pkt(11'h200, 0);
      // Address wrap
      rand_bytes();
      pb[0] = 8'h23;
      run_pkt(11'd2045, 0);
      // Start while busy, then a fresh start right after
      rand_bytes();
      pb[0] = 8'h04;
      run_pkt(11'h300, 1);
      rand_bytes();
      pb[0] = 8'h01;
      run_pkt(11'h340, 0);
      // Reset mid-parse, then a fresh parse
      rand_bytes();
      pb[0] = 8'h02;
      run_pkt(11'h400, 2);
      rand_bytes();
      pb[0] = 8'h05;
      run_pkt(11'h410, 0);
      // Back-to-back data packets
      rand_bytes();
      pb[0] = 8'h02; pb[3] = 8'h00; pb[4] = 8'h0C;
      run_pkt(11'h500, 0);
      rand_bytes();
      pb[0] = 8'h02; pb[3] = 8'h00; pb[4] = 8'h03;
      run_pkt(11'h520, 0);
      // Random packets, bases biased toward the wrap point
      for (int n = 0; n < 40; n++) begin
         rand_bytes();
         if (n % 4 == 0) run_pkt(11'(2038 + $urandom_range(0, 9)), 0);
         else run_pkt(11'($urandom), 0);
      end

      repeat (3) @(negedge clk);
      chk("exp_queue_empty", 32'(exp_q.size()), 32'h0);
      chk("addr_queue_empty", 32'(addr_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by time %0t", $time);
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
